// File: rtl/gaussian_pkg.sv
// gaussian_pkg: shared kernel weights, rounding and sum-width constants for the 3x3 Gaussian blur.
package gaussian_pkg;

    localparam int W_CORNER       = 1;
    localparam int W_EDGE         = 2;
    localparam int W_CENTRE       = 4;
    localparam int NORM_SHIFT     = 4;
    localparam int ROUND_CONST    = 8;
    localparam int SUM_EXTRA_BITS = 4;

    // Kernel weights total 16, so four extra bits hold the full weighted sum.
    function automatic int sum_width(input int pixel_bits);
        return pixel_bits + SUM_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/gaussian_filter_3x3_line_buffer.sv
// line_buffer: single-row pixel store with asynchronous read, so a read and a write
// at the same address in one cycle return the old contents.
module line_buffer #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 12,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[addr] <= din;
    end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// gaussian_filter_3x3: streaming 3x3 Gaussian blur emitting the interior pixels of each frame.
// Define GAUSS_TLAST_EN to add pixel_out_TLAST marking the last output of a frame.
module gaussian_filter_3x3
    import gaussian_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 12,
    parameter int ROWS             = 20,
    parameter int COLS             = 20,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
    input  logic                       pixel_in_TVALID,
    output logic                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
    output logic                       pixel_out_TVALID,
`ifdef GAUSS_TLAST_EN
    output logic                       pixel_out_TLAST,
`endif
    input  logic                       pixel_out_TREADY
);

    localparam int PW = PIXEL_BIT_WIDTH;
    localparam int SW = sum_width(PIXEL_BIT_WIDTH);
    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [IMG_COL_BITWIDTH-1:0] X_LAST = IMG_COL_BITWIDTH'(COLS - 1);
    localparam logic [IMG_ROW_BITWIDTH-1:0] Y_LAST = IMG_ROW_BITWIDTH'(ROWS - 1);

    logic [IMG_COL_BITWIDTH-1:0] x_q, x_d;
    logic [IMG_ROW_BITWIDTH-1:0] y_q, y_d;
    logic [PW-1:0]               data_q, data_d;
    logic                        valid_q, valid_d;
    logic [PW-1:0]               win_q [3][3];
    logic [PW-1:0]               col_in [3];
    logic [PW-1:0]               lb0_dout, lb1_dout;
    logic [SW-1:0]               corners, edges, centre, sum;
    logic                        accept, complete;

    assign pixel_in_TREADY  = ~valid_q | pixel_out_TREADY;
    assign accept           = pixel_in_TVALID & pixel_in_TREADY;
    assign complete         = accept && (y_q >= 2) && (x_q >= 2);
    assign pixel_out_TDATA  = data_q;
    assign pixel_out_TVALID = valid_q;

    line_buffer #(.DEPTH(COLS), .WIDTH(PW)) u_lb0 (
        .clk  (clk),
        .wr_en(accept),
        .addr (x_q[AW-1:0]),
        .din  (pixel_in_TDATA),
        .dout (lb0_dout)
    );

    line_buffer #(.DEPTH(COLS), .WIDTH(PW)) u_lb1 (
        .clk  (clk),
        .wr_en(accept),
        .addr (x_q[AW-1:0]),
        .din  (lb0_dout),
        .dout (lb1_dout)
    );

    // Incoming column, oldest row at index 0.
    assign col_in[0] = lb1_dout;
    assign col_in[1] = lb0_dout;
    assign col_in[2] = pixel_in_TDATA;

    // The sum covers the window as it will look after this accept's shift.
    always_comb begin
        corners = SW'(win_q[0][1]) + SW'(col_in[0]) + SW'(win_q[2][1]) + SW'(col_in[2]);
        edges   = SW'(win_q[0][2]) + SW'(win_q[2][2]) + SW'(win_q[1][1]) + SW'(col_in[1]);
        centre  = SW'(win_q[1][2]);
        sum     = SW'(W_CORNER) * corners + SW'(W_EDGE) * edges + SW'(W_CENTRE) * centre;
        x_d     = !accept ? x_q : (x_q == X_LAST) ? '0 : x_q + 1'b1;
        y_d     = !(accept && x_q == X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        data_d  = complete ? PW'((sum + SW'(ROUND_CONST)) >> NORM_SHIFT) : data_q;
        valid_d = complete | (valid_q & ~pixel_out_TREADY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                    win_q[r][2] <= col_in[r];
                end
            end
        end
    end

`ifdef GAUSS_TLAST_EN
    logic last_q, last_d;

    assign pixel_out_TLAST = last_q;
    assign last_d          = complete ? (y_q == Y_LAST && x_q == X_LAST) : last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b0;
        else        last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// tb_gaussian_filter_3x3: scoreboard bench for the 3x3 Gaussian blur with directed frames.
module tb_gaussian_filter_3x3;

    localparam int P = 12;
    localparam int R = 20;
    localparam int C = 20;
    localparam int KIND_FLAT = 0;
    localparam int KIND_IMP  = 1;

    typedef struct {
        logic [P-1:0] d;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [P-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [P-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
`ifdef GAUSS_TLAST_EN
    logic         out_last;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   bx = 0;
    int   by = 0;
    bit   lat_set = 0;
    bit   lat_chk = 0;

    always #5 clk = ~clk;

    gaussian_filter_3x3 dut (
        .clk             (clk),
        .reset           (rst_n),
        .pixel_in_TDATA  (in_data),
        .pixel_in_TVALID (in_valid),
        .pixel_in_TREADY (in_ready),
        .pixel_out_TDATA (out_data),
        .pixel_out_TVALID(out_valid),
`ifdef GAUSS_TLAST_EN
        .pixel_out_TLAST (out_last),
`endif
        .pixel_out_TREADY(out_ready)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [P-1:0] pix(input int kind, input int v, input int y, input int x);
        if (kind == KIND_IMP) return (y == 5 && x == 5) ? P'(16) : '0;
        return P'(v);
    endfunction

    // Impulse of 16 at (5,5): the blurred value is the kernel weight itself.
    function automatic logic [P-1:0] expv(input int kind, input int v, input int cy, input int cx);
        int k[3] = '{1, 2, 1};
        int dy = cy - 5;
        int dx = cx - 5;
        if (kind != KIND_IMP) return P'(v);
        if (dy < -1 || dy > 1 || dx < -1 || dx > 1) return '0;
        return P'(k[dy+1] * k[dx+1]);
    endfunction

    task automatic send_px(input int kind, input int v, input bit rnd);
        bit acc = 0;
        int tries = 0;
        while (!acc) begin
            @(negedge clk);
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = pix(kind, v, by, bx);
            #1;
            acc = in_valid && in_ready;
            tries++;
            if (tries > 1000) begin
                $display("FAIL accept_timeout: got=stalled expected=accept at %0t", $time);
                $fatal(1, "input never accepted");
            end
        end
        if (by >= 2 && bx >= 2) begin
            q.push_back('{expv(kind, v, by - 1, bx - 1), (by == R - 1 && bx == C - 1)});
            if (!rnd) lat_set = 1;
        end
        if (bx == C - 1) begin
            bx = 0;
            by = (by == R - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic send_frame(input int kind, input int v, input bit rnd, input int n);
        for (int i = 0; i < n; i++) send_px(kind, v, rnd);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold under stall.
    initial begin
        bit           prev_stall = 0;
        logic [P-1:0] prev_d = '0;
        logic         prev_l = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 0;
                lat_chk = 0;
                continue;
            end
            if (lat_chk) chk("latency_valid", int'(out_valid), 1);
            lat_chk = lat_set;
            lat_set = 0;
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_d));
`ifdef GAUSS_TLAST_EN
                chk("hold_last", int'(out_last), int'(prev_l));
`endif
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", int'(out_data), -1);
                end else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
`ifdef GAUSS_TLAST_EN
                    chk("out_last", int'(out_last), int'(e.l));
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
`ifdef GAUSS_TLAST_EN
            prev_l     = out_last;
`endif
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", int'(in_ready), 1);

        send_frame(KIND_FLAT, 100, 0, R * C);
        drain();
        send_frame(KIND_IMP, 0, 0, R * C);
        drain();
        send_frame(KIND_FLAT, 4095, 0, R * C);
        drain();
        send_frame(KIND_IMP, 0, 1, R * C);
        send_frame(KIND_FLAT, 100, 1, R * C);
        drain();
        send_frame(KIND_FLAT, 0, 0, R * C);
        send_frame(KIND_FLAT, 200, 0, R * C);
        drain();

        // Abandon a frame mid-way; its pending output must never appear.
        send_frame(KIND_FLAT, 300, 0, 150);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        bx = 0;
        by = 0;
        lat_set = 0;
        #1;
        chk("midreset_valid", int'(out_valid), 0);
        chk("midreset_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(KIND_IMP, 0, 0, R * C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
